// File: rtl/weight_update_pkg.sv
// Shared definitions for the batched gate-parameter updater:
// FSM encoding, parameter count and flat-index layout.
package weight_update_pkg;

    typedef enum logic [1:0] {
        ST_ACC  = 2'd0,
        ST_UPD  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int NUM_DEF   = 2;
    localparam int BIAS_BASE = 0;
    localparam int WA_BASE   = 4;

    function automatic int num_params(input int num);
        return 4 + 4 * num;
    endfunction

    function automatic int wi_base(input int num);
        return 4 + num;
    endfunction

    function automatic int wf_base(input int num);
        return 4 + 2 * num;
    endfunction

    function automatic int wo_base(input int num);
        return 4 + 3 * num;
    endfunction

    localparam int P_DEF = 4 + 4 * NUM_DEF;

endpackage

// File: rtl/weight_update_mul_sat.sv
// Signed fixed-point multiply, arithmetic shift by FRAC,
// saturated back to WIDTH bits.
module wu_mul_sat #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] p_o
);

    localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] shr;
    logic [WIDTH:0]            hi;
    logic                      fits;

    assign prod = $signed(a_i) * $signed(b_i);
    assign shr  = prod >>> FRAC;
    assign hi   = shr[2*WIDTH-1:WIDTH-1];

    // Result fits when all bits above the new sign bit copy it.
    assign fits = (&hi) | (~|hi);

    assign p_o = fits ? shr[WIDTH-1:0]
               : (shr[2*WIDTH-1] ? MINV : MAXV);

endmodule

// File: rtl/weight_update.sv
// Accumulates gradient sets over a batch, then applies
// param -= (lr * acc) >>> FRAC one parameter per cycle.
module weight_update
    import weight_update_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24,
    parameter int NUM   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_load,
    input  logic [4*WIDTH-1:0]     i_init_b,
    input  logic [4*NUM*WIDTH-1:0] i_init_w,
    input  logic                   i_valid,
    input  logic                   i_last,
    input  logic [4*WIDTH-1:0]     i_db,
    input  logic [NUM*WIDTH-1:0]   i_dwa,
    input  logic [NUM*WIDTH-1:0]   i_dwi,
    input  logic [NUM*WIDTH-1:0]   i_dwf,
    input  logic [NUM*WIDTH-1:0]   i_dwo,
    input  logic [WIDTH-1:0]       i_lr,
    output logic                   o_ready,
    output logic [4*WIDTH-1:0]     o_b,
    output logic [NUM*WIDTH-1:0]   o_wa,
    output logic [NUM*WIDTH-1:0]   o_wi,
    output logic [NUM*WIDTH-1:0]   o_wf,
    output logic [NUM*WIDTH-1:0]   o_wo,
    output logic                   o_done
);

    localparam int P  = num_params(NUM);
    localparam int IW = (P > 1) ? $clog2(P) : 1;

    typedef logic [WIDTH-1:0] word_t;

    localparam word_t MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam word_t MINV = {1'b1, {(WIDTH-1){1'b0}}};

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          done_q, done_d;
    word_t         param_q [P];
    word_t         param_d [P];
    word_t         acc_q   [P];
    word_t         acc_d   [P];

    logic [P*WIDTH-1:0] init_flat;
    logic [P*WIDTH-1:0] grad_flat;
    word_t              mul_p;
    word_t              upd_val;

    // Packed buses are LSB-first in flat-index order.
    assign init_flat = {i_init_w, i_init_b};
    assign grad_flat = {i_dwo, i_dwf, i_dwi, i_dwa, i_db};

    function automatic word_t sat_add(input word_t a, input word_t b);
        logic [WIDTH:0] s;
        s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        if (s[WIDTH] != s[WIDTH-1])
            return s[WIDTH] ? MINV : MAXV;
        return s[WIDTH-1:0];
    endfunction

    function automatic word_t sat_sub(input word_t a, input word_t b);
        logic [WIDTH:0] s;
        s = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        if (s[WIDTH] != s[WIDTH-1])
            return s[WIDTH] ? MINV : MAXV;
        return s[WIDTH-1:0];
    endfunction

    wu_mul_sat #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_mul (
        .a_i (i_lr),
        .b_i (acc_q[idx_q]),
        .p_o (mul_p)
    );

    assign upd_val = sat_sub(param_q[idx_q], mul_p);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        param_d = param_q;
        acc_d   = acc_q;
        unique case (state_q)
            ST_ACC: begin
                if (i_load) begin
                    for (int i = 0; i < P; i++) begin
                        param_d[i] = init_flat[i*WIDTH +: WIDTH];
                        acc_d[i]   = '0;
                    end
                end else if (i_valid) begin
                    for (int i = 0; i < P; i++)
                        acc_d[i] = sat_add(acc_q[i],
                                           grad_flat[i*WIDTH +: WIDTH]);
                    if (i_last) begin
                        state_d = ST_UPD;
                        idx_d   = '0;
                    end
                end
            end
            ST_UPD: begin
                param_d[idx_q] = upd_val;
                if (idx_q == IW'(P-1))
                    state_d = ST_DONE;
                else
                    idx_d = idx_q + 1'b1;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_ACC;
                idx_d   = '0;
                for (int i = 0; i < P; i++)
                    acc_d[i] = '0;
            end
            default: begin
                state_d = ST_ACC;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ACC;
            idx_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < P; i++) begin
                param_q[i] <= '0;
                acc_q[i]   <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            for (int i = 0; i < P; i++) begin
                param_q[i] <= param_d[i];
                acc_q[i]   <= acc_d[i];
            end
        end
    end

    assign o_ready = (state_q == ST_ACC);
    assign o_done  = done_q;

    for (genvar g = 0; g < 4; g++) begin : g_bias
        assign o_b[g*WIDTH +: WIDTH] = param_q[BIAS_BASE + g];
    end

    for (genvar g = 0; g < NUM; g++) begin : g_wts
        assign o_wa[g*WIDTH +: WIDTH] = param_q[WA_BASE + g];
        assign o_wi[g*WIDTH +: WIDTH] = param_q[wi_base(NUM) + g];
        assign o_wf[g*WIDTH +: WIDTH] = param_q[wf_base(NUM) + g];
        assign o_wo[g*WIDTH +: WIDTH] = param_q[wo_base(NUM) + g];
    end

endmodule

// File: tb/tb_weight_update.sv
// Self-checking bench for weight_update: table-driven batches
// with a scoreboard of expected parameter sets, plus corner cases.
module tb_weight_update;

    localparam int W = 32;
    localparam int N = 2;
    localparam int P = 4 + 4 * N;
    localparam logic [31:0] ONE  = 32'h0100_0000;
    localparam logic [31:0] HALF = 32'h0080_0000;

    typedef logic [P*W-1:0] pvec_t;

    typedef struct {
        logic [31:0] init;
        logic [31:0] grad;
        logic [31:0] lr;
        int          n;
        logic [31:0] exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_load, i_valid, i_last;
    logic [4*W-1:0]   i_init_b, i_db;
    logic [4*N*W-1:0] i_init_w;
    logic [N*W-1:0]   i_dwa, i_dwi, i_dwf, i_dwo;
    logic [W-1:0]     i_lr;
    logic             o_ready, o_done;
    logic [4*W-1:0]   o_b;
    logic [N*W-1:0]   o_wa, o_wi, o_wf, o_wo;

    int    checks   = 0;
    int    failures = 0;
    pvec_t exp_q[$];
    vec_t  tbl[7];

    weight_update #(.WIDTH(W), .FRAC(24), .NUM(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_load   (i_load),
        .i_init_b (i_init_b),
        .i_init_w (i_init_w),
        .i_valid  (i_valid),
        .i_last   (i_last),
        .i_db     (i_db),
        .i_dwa    (i_dwa),
        .i_dwi    (i_dwi),
        .i_dwf    (i_dwf),
        .i_dwo    (i_dwo),
        .i_lr     (i_lr),
        .o_ready  (o_ready),
        .o_b      (o_b),
        .o_wa     (o_wa),
        .o_wi     (o_wi),
        .o_wf     (o_wf),
        .o_wo     (o_wo),
        .o_done   (o_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_params(input string nm, input pvec_t exp);
        pvec_t c;
        c = {o_wo, o_wf, o_wi, o_wa, o_b};
        for (int k = 0; k < P; k++)
            chk($sformatf("%s[%0d]", nm, k), c[k*W +: W], exp[k*W +: W]);
    endtask

    function automatic pvec_t fill(input logic [31:0] v);
        pvec_t r;
        for (int k = 0; k < P; k++) r[k*W +: W] = v;
        return r;
    endfunction

    task automatic idle();
        i_load  = 1'b0;
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic do_load(input pvec_t init);
        @(negedge clk);
        i_init_b = init[4*W-1:0];
        i_init_w = init[P*W-1:4*W];
        i_load   = 1'b1;
        i_valid  = 1'b0;
        i_last   = 1'b0;
        @(negedge clk);
        idle();
    endtask

    task automatic send(input pvec_t g, input logic last);
        @(negedge clk);
        {i_dwo, i_dwf, i_dwi, i_dwa, i_db} = g;
        i_valid = 1'b1;
        i_last  = last;
    endtask

    // Called right after the last set is driven; cnt counts
    // negedges, so the accept edge precedes cnt == 1.
    task automatic wait_done(input string nm, input bit perturb);
        int    cnt;
        bit    seen;
        pvec_t e;
        cnt  = 0;
        seen = 1'b0;
        while (cnt < 40 && !seen) begin
            @(negedge clk);
            cnt++;
            if (o_done) begin
                seen = 1'b1;
                idle();
            end else begin
                chk({nm, "_ready_low"}, {31'd0, o_ready}, 32'd0);
                if (perturb) begin
                    i_load   = 1'b1;
                    i_valid  = 1'b1;
                    i_last   = cnt[0];
                    i_init_b = {4{$urandom()}};
                    i_init_w = {8{$urandom()}};
                    {i_dwo, i_dwf, i_dwi, i_dwa, i_db} = {P{$urandom()}};
                end else begin
                    idle();
                end
            end
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        if (!seen) begin
            failures++;
            $display("FAIL %s_timeout: no o_done within 40 cycles", nm);
        end else begin
            chk({nm, "_latency"}, cnt - 1, 32'd13);
            chk({nm, "_ready_after"}, {31'd0, o_ready}, 32'd1);
            chk_params(nm, e);
            @(negedge clk);
            chk({nm, "_done_pulse"}, {31'd0, o_done}, 32'd0);
        end
    endtask

    task automatic run_vec(input int v);
        string nm;
        nm = $sformatf("vec%0d", v);
        do_load(fill(tbl[v].init));
        chk_params({nm, "_load"}, fill(tbl[v].init));
        i_lr = tbl[v].lr;
        for (int s = 0; s < tbl[v].n; s++)
            send(fill(tbl[v].grad), (s == tbl[v].n - 1));
        exp_q.push_back(fill(tbl[v].exp));
        wait_done(nm, 1'b0);
    endtask

    initial begin
        pvec_t g, e;
        bit    stray;

        tbl[0] = '{ONE,          ONE,          HALF,         2, 32'h0000_0000};
        tbl[1] = '{32'h0,        32'h7F00_0000, ONE,         2, 32'h8000_0001};
        tbl[2] = '{32'h0,        ONE,          32'h0040_0000, 3, 32'hFF40_0000};
        tbl[3] = '{32'h8000_0000, ONE,         ONE,          1, 32'h8000_0000};
        tbl[4] = '{32'h0,        32'h8000_0000, ONE,         2, 32'h7FFF_FFFF};
        tbl[5] = '{32'h0,        32'h7FFF_FFFF, 32'h7FFF_FFFF, 1, 32'h8000_0001};
        tbl[6] = '{ONE,          ONE,          32'hFF00_0000, 1, 32'h0200_0000};

        rst = 1'b1;
        idle();
        i_init_b = '0;
        i_init_w = '0;
        i_lr     = '0;
        {i_dwo, i_dwf, i_dwi, i_dwa, i_db} = '0;
        #12;
        chk("reset_ready", {31'd0, o_ready}, 32'd1);
        chk("reset_done", {31'd0, o_done}, 32'd0);
        chk_params("reset_params", '0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 7; v++) run_vec(v);

        // Single a-lane bias gradient of -0.25 at lr = 1.0.
        do_load('0);
        i_lr = ONE;
        g = '0;
        g[31:0] = 32'hFFC0_0000;
        send(g, 1'b1);
        e = '0;
        e[31:0] = 32'h0040_0000;
        exp_q.push_back(e);
        wait_done("bias_a", 1'b0);

        // Load and valid during UPD must be ignored.
        do_load(fill(ONE));
        i_lr = HALF;
        send(fill(ONE), 1'b0);
        send(fill(ONE), 1'b1);
        exp_q.push_back(fill(32'h0));
        wait_done("perturb", 1'b1);

        // Load wins over a simultaneous valid; accumulators clear.
        @(negedge clk);
        i_init_b = {4{32'h0010_0000}};
        i_init_w = {8{32'h0010_0000}};
        {i_dwo, i_dwf, i_dwi, i_dwa, i_db} = fill(ONE);
        i_load  = 1'b1;
        i_valid = 1'b1;
        i_last  = 1'b0;
        @(negedge clk);
        idle();
        chk_params("load_prio", fill(32'h0010_0000));
        i_lr = ONE;
        send('0, 1'b1);
        exp_q.push_back(fill(32'h0010_0000));
        wait_done("load_prio_upd", 1'b0);

        // Reset asserted with idx = 5 abandons the update.
        do_load(fill(ONE));
        i_lr = HALF;
        send(fill(ONE), 1'b1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            idle();
        end
        chk("mid_ready_low", {31'd0, o_ready}, 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", {31'd0, o_ready}, 32'd1);
        chk("mid_rst_done", {31'd0, o_done}, 32'd0);
        chk_params("mid_rst", '0);
        @(negedge clk);
        rst   = 1'b0;
        stray = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (o_done) stray = 1'b1;
        end
        chk("mid_rst_no_done", {31'd0, stray}, 32'd0);
        chk_params("mid_rst_hold", '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
